calc_sequencer: RTL
===================

Name: calc_sequencer

Overview:
- Top-level controller for the lab calculator datapath.
- Steps the user through operand 1, operand 2 and operation entry with the centre button, then issues one start pulse to the ALU and waits for its done handshake.
- Holds operands, operation and result in registers and selects what the 7-segment display shows. Times out if the ALU never responds.
- Sits between the board debouncers/switches and the ALU and display driver.

Parameters:
- W, 16, operand/result width (switch field width).
- OPW, 2, operation code width (taken from sw[OPW-1:0]).
- TIMEOUT, 64, maximum cycles spent in EXEC waiting for alu_done.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- BTNC  in  1  debounced centre button, level
- BTNU  in  1  debounced clear button, level
- sw  in  W  switch input
- alu_a  out  W  registered operand 1
- alu_b  out  W  registered operand 2
- alu_op  out  OPW  registered operation code
- alu_start  out  1  one-cycle start pulse
- alu_done  in  1  ALU result valid, sampled only in EXEC
- alu_result  in  W  ALU result, sampled when alu_done=1 in EXEC
- display_value  out  W  value for display driver
- estado  out  3  current state encoding
- error  out  1  high in SHOW_RESULT after a timeout

Behaviour:
- All registers update on posedge clk. Reset is synchronous and active-high, and has priority over everything.
- Reset values: state=WAIT_OP1; alu_a, alu_b, alu_op and result = 0; alu_start=0; error=0; edge registers=0; timeout counter=0.
- Edge detect:
  - pressC = BTNC & ~BTNC_q; pressU = BTNU & ~BTNU_q.
  - BTNC_q and BTNU_q are registered every cycle.
  - A held button yields exactly one press.
- State encodings (estado): WAIT_OP1=0, WAIT_OP2=1, WAIT_OP=2, EXEC=3, SHOW_RESULT=4. Any unused encoding goes to WAIT_OP1 on the next cycle.
- Clear: pressU in any state → WAIT_OP1 next cycle.
  - Clears alu_a, alu_b, alu_op, result and error to 0, and alu_start to 0.
  - pressU beats a simultaneous pressC.
  - pressU during EXEC abandons the operation; a later alu_done is ignored.
- WAIT_OP1: display_value=sw. On pressC, alu_a<=sw and go to WAIT_OP2.
- WAIT_OP2: display_value=sw. On pressC, alu_b<=sw and go to WAIT_OP.
- WAIT_OP: display_value = zero-extended sw[OPW-1:0]. On pressC, alu_op<=sw[OPW-1:0], go to EXEC, and alu_start<=1.
- alu_start:
  - Registered; high exactly during the first EXEC cycle, low otherwise.
  - One start per entry into EXEC.
- EXEC: display_value=result (previous value).
  - pressC is ignored, but BTNC_q still updates, so a press here is consumed.
  - The counter increments each EXEC cycle, starting at 0 on entry.
  - If alu_done=1 (including in the alu_start cycle): result<=alu_result, error<=0, go to SHOW_RESULT.
  - Else if counter==TIMEOUT-1: result<=0, error<=1, go to SHOW_RESULT.
  - If done and timeout occur in the same cycle, done wins.
- SHOW_RESULT: display_value=result; error holds.
  - On pressC, go to WAIT_OP1 and set error<=0.
  - Operand registers keep their values until overwritten.
- alu_done outside EXEC is ignored.
- Latencies:
  - A press is visible at the state output one cycle after the edge where BTNC first samples high.
  - With a combinational ALU (done tied to start), EXEC lasts 1 cycle.

Test Plan:
- Reset, then hold BTNC high for 10 cycles → exactly one transition, estado 0→1; hold reset 3 cycles mid-sequence → estado=0, alu_a=0, error=0.
- sw=0x0012 press, sw=0x0034 press, sw=0x0001 press; ALU returns done 3 cycles after start with result 0x0046 → alu_a=0x12, alu_b=0x34, alu_op=1, single alu_start pulse, estado=4, display_value=0x0046, error=0.
- Same entry with alu_done tied to alu_start → EXEC lasts 1 cycle, result latched; press in SHOW_RESULT → estado=0, display_value=sw.
- Full entry, alu_done never asserted, TIMEOUT=64 → exactly 64 cycles in EXEC, then estado=4, display_value=0, error=1; next BTNC press → estado=0, error=0.
- BTNU and BTNC rising in the same cycle while in WAIT_OP2 → estado=0, alu_a=0 (clear wins); BTNU in EXEC then alu_done=1 → stays WAIT_OP1, result unchanged at 0.
- BTNC pressed during EXEC, then done → estado=4 and stays there (press not replayed); alu_done pulsed in WAIT_OP1 → no state or result change.

Source files
------------

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Purpose  : Calculator front-end controller. Collects operand 1, operand 2
//            and an operation code from the switches on centre-button
//            presses, issues a single start pulse to the ALU, waits for its
//            done handshake (bounded by TIMEOUT cycles) and selects the
//            value shown on the 7-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
    parameter int W       = 16,
    parameter int OPW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           BTNC,
    input  logic           BTNU,
    input  logic [W-1:0]   sw,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    output logic           alu_start,
    input  logic           alu_done,
    input  logic [W-1:0]   alu_result,
    output logic [W-1:0]   display_value,
    output logic [2:0]     estado,
    output logic           error
);

    // State encoding is visible on the estado port, so it is fixed here.
    localparam logic [2:0] c_S_WAIT_OP1    = 3'd0;
    localparam logic [2:0] c_S_WAIT_OP2    = 3'd1;
    localparam logic [2:0] c_S_WAIT_OP     = 3'd2;
    localparam logic [2:0] c_S_EXEC        = 3'd3;
    localparam logic [2:0] c_S_SHOW_RESULT = 3'd4;

    // Counter wide enough to hold TIMEOUT-1 without wrapping.
    localparam int              c_CW       = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [2:0]      r_state;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [OPW-1:0]  r_alu_op;
    logic [W-1:0]    r_result;
    logic            r_alu_start;
    logic            r_error;
    logic [c_CW-1:0] r_cnt;
    logic            r_btnc_q;
    logic            r_btnu_q;

    logic            w_press_c;
    logic            w_press_u;
    logic [W-1:0]    w_display;

    // A held level yields a single press on its rising edge only.
    assign w_press_c = BTNC & ~r_btnc_q;
    assign w_press_u = BTNU & ~r_btnu_q;

    // Button history, sampled every cycle so presses in EXEC are consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btnc_q <= 1'b0;
            r_btnu_q <= 1'b0;
        end else begin
            r_btnc_q <= BTNC;
            r_btnu_q <= BTNU;
        end
    end

    // Sequencer: operand/op capture, ALU launch, done/timeout, clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_WAIT_OP1;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_result    <= '0;
            r_alu_start <= 1'b0;
            r_error     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            // Start is a one-cycle pulse; only the WAIT_OP launch raises it.
            r_alu_start <= 1'b0;
            if (w_press_u) begin
                // Clear beats any simultaneous centre press and abandons EXEC.
                r_state  <= c_S_WAIT_OP1;
                r_alu_a  <= '0;
                r_alu_b  <= '0;
                r_alu_op <= '0;
                r_result <= '0;
                r_error  <= 1'b0;
                r_cnt    <= '0;
            end else begin
                case (r_state)
                    c_S_WAIT_OP1: begin
                        if (w_press_c) begin
                            r_alu_a <= sw;
                            r_state <= c_S_WAIT_OP2;
                        end
                    end
                    c_S_WAIT_OP2: begin
                        if (w_press_c) begin
                            r_alu_b <= sw;
                            r_state <= c_S_WAIT_OP;
                        end
                    end
                    c_S_WAIT_OP: begin
                        if (w_press_c) begin
                            r_alu_op    <= sw[OPW-1:0];
                            r_alu_start <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= c_S_EXEC;
                        end
                    end
                    c_S_EXEC: begin
                        // Done has priority over a timeout in the same cycle.
                        if (alu_done) begin
                            r_result <= alu_result;
                            r_error  <= 1'b0;
                            r_state  <= c_S_SHOW_RESULT;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_result <= '0;
                            r_error  <= 1'b1;
                            r_state  <= c_S_SHOW_RESULT;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_S_SHOW_RESULT: begin
                        if (w_press_c) begin
                            r_error <= 1'b0;
                            r_state <= c_S_WAIT_OP1;
                        end
                    end
                    default: begin
                        r_state <= c_S_WAIT_OP1;
                    end
                endcase
            end
        end
    end

    // Display follows live switches while entering, the result afterwards.
    always_comb begin
        w_display = '0;
        case (r_state)
            c_S_WAIT_OP1:    w_display = sw;
            c_S_WAIT_OP2:    w_display = sw;
            c_S_WAIT_OP:     w_display = {{(W-OPW){1'b0}}, sw[OPW-1:0]};
            c_S_EXEC:        w_display = r_result;
            c_S_SHOW_RESULT: w_display = r_result;
            default:         w_display = '0;
        endcase
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_op        = r_alu_op;
    assign alu_start     = r_alu_start;
    assign display_value = w_display;
    assign estado        = r_state;
    assign error         = r_error;

endmodule
`default_nettype wire
